vid_frame_ctrl: RTL and testbench

- Frame-synchronous controller between the HDMI receiver and the convolution filter, on the pixel clock domain.
- Tracks incoming video timing, measures the active frame geometry, and declares lock once geometry is stable.
- Provides per-pixel x/y coordinates to the filter.
- Debounces the user switch word and commits it to the filter only at frame boundaries, so mode changes never tear mid-frame.
- Forces filter bypass whenever timing is not locked.

---
 rtl/vid_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_vid_frame_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vid_frame_ctrl.sv
// vid_frame_ctrl: video timing lock, geometry measurement and frame-aligned filter configuration
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   sw                       raw asynchronous user switches
//   rx_dv, rx_hs, rx_vs      receiver active-video qualifier, hsync, vsync
//   cfg_mode, cfg_update     committed filter configuration and its one-cycle change pulse
//   cfg_bypass               filter pass-through request while timing is unlocked
//   x_pos, y_pos             coordinates of the current active pixel
//   h_active, v_active       geometry of the last complete locked frame
//   locked, status           lock flag and {locked, state, sticky geometry mismatch}
module vid_frame_ctrl #(
   parameter int CW          = 12,
   parameter int LOCK_FRAMES = 2,
   parameter int DEB_CYCLES  = 65536,
   parameter int TIMEOUT     = 4000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    sw,
   input  logic          rx_dv,
   input  logic          rx_hs,
   input  logic          rx_vs,
   output logic [7:0]    cfg_mode,
   output logic          cfg_update,
   output logic          cfg_bypass,
   output logic [CW-1:0] x_pos,
   output logic [CW-1:0] y_pos,
   output logic [CW-1:0] h_active,
   output logic [CW-1:0] v_active,
   output logic          locked,
   output logic [3:0]    status
);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [3:0]    LF1  = 4'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {WAIT_VS = 2'b00, MEASURE = 2'b01, LOCKED = 2'b10} state_t;
   state_t state, state_nx;

   logic          vs_d, dv_d, frame_mis, sticky;
   logic [CW-1:0] pix_cnt, line_cnt, cur_w, prev_w, prev_l;
   logic [3:0]    match_cnt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    sw_s1, sw_s2, sw_q, pending;
   logic [DW-1:0] deb_cnt;

   logic          vs_rise, dv_fall, first_line, pix_sat, fin_mis, good, lock_now, to_hit, commit;
   logic [CW-1:0] fin_w, fin_l;
   logic [3:0]    m_nx;

   assign vs_rise    = rx_vs & ~vs_d;
   assign dv_fall    = ~rx_dv & dv_d;
   assign first_line = line_cnt == '0;
   assign pix_sat    = rx_dv & (pix_cnt == CMAX);
   // fin_* are the frame totals with any line ending this cycle already closed,
   // so a vs_rise coinciding with dv_fall still accounts for the last line.
   assign fin_w   = (dv_fall && first_line) ? pix_cnt : cur_w;
   assign fin_l   = (dv_fall && line_cnt != CMAX) ? line_cnt + 1'b1 : line_cnt;
   assign fin_mis = frame_mis | pix_sat |
                    (dv_fall & ((~first_line & (pix_cnt != cur_w)) | (line_cnt == CMAX)));
   assign good     = fin_w == prev_w && fin_l == prev_l && fin_w != '0 && fin_l != '0 && !fin_mis;
   assign m_nx     = match_cnt + 4'd1;
   assign lock_now = good && m_nx >= LF1;
   // Timeout is not taken in the middle of an hsync pulse.
   assign to_hit   = to_cnt == TMAX && !rx_hs && !vs_rise;
   assign commit   = (locked ? vs_rise : 1'b1) && pending != cfg_mode;
   assign y_pos    = line_cnt;
   assign status   = {locked, state, sticky};

   always_comb begin
      state_nx = state;
      if (to_hit)
         state_nx = WAIT_VS;
      else if (vs_rise)
         state_nx = state == WAIT_VS ? MEASURE :
                    state == MEASURE ? (lock_now ? LOCKED : MEASURE) :
                    (good ? LOCKED : MEASURE);
   end

   always_ff @(posedge clk) state <= rst ? WAIT_VS : state_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d <= 1'b0; dv_d <= 1'b0; frame_mis <= 1'b0; sticky <= 1'b0;
         pix_cnt <= '0; line_cnt <= '0; cur_w <= '0; prev_w <= '0; prev_l <= '0;
         match_cnt <= '0; to_cnt <= '0; x_pos <= '0; h_active <= '0; v_active <= '0;
         locked <= 1'b0; cfg_bypass <= 1'b1; cfg_mode <= '0; cfg_update <= 1'b0;
         sw_s1 <= '0; sw_s2 <= '0; sw_q <= '0; pending <= '0; deb_cnt <= '0;
      end else begin
         vs_d <= rx_vs;
         dv_d <= rx_dv;
         if (rx_dv) begin
            x_pos   <= pix_cnt;
            pix_cnt <= pix_sat ? pix_cnt : pix_cnt + 1'b1;
         end else if (dv_fall)
            pix_cnt <= '0;
         line_cnt  <= vs_rise ? '0 : fin_l;
         cur_w     <= vs_rise ? '0 : fin_w;
         frame_mis <= ~vs_rise & fin_mis;
         to_cnt    <= vs_rise ? '0 : (to_cnt == TMAX ? to_cnt : to_cnt + 1'b1);
         if (to_hit)
            match_cnt <= '0;
         else if (vs_rise) begin
            match_cnt <= (state == MEASURE && good && !lock_now) ? m_nx : '0;
            // Leaving WAIT_VS the partial frame seen so far is not a valid reference.
            prev_w    <= state == WAIT_VS ? '0 : fin_w;
            prev_l    <= state == WAIT_VS ? '0 : fin_l;
            sticky    <= sticky | (state != WAIT_VS && !good);
            if (state_nx == LOCKED) begin
               h_active <= fin_w;
               v_active <= fin_l;
            end
         end
         locked     <= state_nx == LOCKED;
         cfg_bypass <= state_nx != LOCKED;
         sw_s1      <= sw;
         sw_s2      <= sw_s1;
         sw_q       <= sw_s2;
         deb_cnt    <= sw_s2 != sw_q ? '0 : (deb_cnt == DMAX ? deb_cnt : deb_cnt + 1'b1);
         if (deb_cnt == DMAX) pending <= sw_q;
         cfg_update <= commit;
         if (commit) cfg_mode <= pending;
      end
   end
endmodule

// File: tb/tb_vid_frame_ctrl.sv
// tb_vid_frame_ctrl: directed self-checking bench for vid_frame_ctrl
module tb_vid_frame_ctrl;
   localparam int CW = 12;
   logic          clk = 1'b0, rst, rx_dv, rx_hs, rx_vs, cfg_update, cfg_bypass, locked;
   logic [7:0]    sw, cfg_mode;
   logic [CW-1:0] x_pos, y_pos, h_active, v_active;
   logic [3:0]    status;
   int            checks = 0, failures = 0, upd_cnt = 0;

   vid_frame_ctrl #(.CW(CW), .LOCK_FRAMES(2), .DEB_CYCLES(16), .TIMEOUT(2000)) dut (
      .clk(clk), .rst(rst), .sw(sw), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
      .cfg_mode(cfg_mode), .cfg_update(cfg_update), .cfg_bypass(cfg_bypass),
      .x_pos(x_pos), .y_pos(y_pos), .h_active(h_active), .v_active(v_active),
      .locked(locked), .status(status));

   always #5 clk = ~clk;

   always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_cfg_mode"}, cfg_mode, 0);
      chk({p, "_cfg_update"}, cfg_update, 0);
      chk({p, "_cfg_bypass"}, cfg_bypass, 1);
      chk({p, "_x_pos"}, x_pos, 0);
      chk({p, "_y_pos"}, y_pos, 0);
      chk({p, "_h_active"}, h_active, 0);
      chk({p, "_v_active"}, v_active, 0);
      chk({p, "_locked"}, locked, 0);
      chk({p, "_status"}, status, 0);
   endtask

   task automatic vs_edge();
      rx_vs = 1'b1;
      tick();
   endtask

   task automatic vs_tail();
      tick(); tick();
      rx_vs = 1'b0;
      repeat (5) tick();
   endtask

   // tight: the last line's dv falls on the same edge as the following vs rise
   task automatic frame(input int w, input int l, input bit tight, input bit pchk);
      for (int ln = 0; ln < l; ln++) begin
         rx_dv = 1'b1;
         for (int px = 0; px < w; px++) begin
            tick();
            if (pchk && ln == 3 && px == 9) begin
               chk("x_pos_mid", x_pos, 9);
               chk("y_pos_mid", y_pos, 3);
            end
         end
         rx_dv = 1'b0;
         if (!(tight && ln == l - 1)) begin
            rx_hs = 1'b1; tick(); tick();
            rx_hs = 1'b0; repeat (6) tick();
         end
      end
      if (!tight) repeat (10) tick();
   endtask

   initial begin
      rst = 1'b1; sw = 8'h00; rx_dv = 1'b0; rx_hs = 1'b0; rx_vs = 1'b0;
      repeat (3) tick();
      chk_reset("rst");
      rst = 1'b0;

      // acquire lock on 64x16 frames
      vs_edge(); vs_tail();
      frame(64, 16, 0, 1);
      vs_edge();
      chk("lock_vs2", locked, 0);
      chk("status_vs2", status, 4'b0011);
      vs_tail();
      frame(64, 16, 0, 0);
      chk("lock_pre_vs3", locked, 0);
      vs_edge();
      chk("lock_vs3", locked, 1);
      chk("bypass_vs3", cfg_bypass, 0);
      chk("h_active_vs3", h_active, 64);
      chk("v_active_vs3", v_active, 16);
      chk("status_vs3", status, 4'b1101);
      vs_tail();

      // switch change commits only at the next frame boundary
      upd_cnt = 0;
      sw = 8'h05;
      frame(64, 16, 0, 0);
      chk("mode_hold", cfg_mode, 8'h00);
      chk("upd_hold", upd_cnt, 0);
      vs_edge();
      chk("mode_commit", cfg_mode, 8'h05);
      chk("upd_pulse", cfg_update, 1);
      chk("lock_commit", locked, 1);
      tick();
      chk("upd_drop", cfg_update, 0);
      vs_tail();
      chk("upd_once", upd_cnt, 1);

      // last line closing on the vs edge itself
      frame(64, 16, 1, 0);
      vs_edge();
      chk("lock_tight", locked, 1);
      chk("v_active_tight", v_active, 16);
      chk("h_active_tight", h_active, 64);
      vs_tail();

      // narrow frame drops lock, two clean frames relock
      frame(63, 16, 0, 0);
      vs_edge();
      chk("lock_bad", locked, 0);
      chk("bypass_bad", cfg_bypass, 1);
      chk("status_bad", status, 4'b0011);
      vs_tail();
      frame(64, 16, 0, 0);
      vs_edge();
      chk("lock_clean1", locked, 0);
      vs_tail();
      frame(64, 16, 0, 0);
      vs_edge();
      chk("lock_clean2", locked, 1);
      chk("h_active_relock", h_active, 64);
      vs_tail();

      // vsync loss
      repeat (1900) tick();
      chk("lock_before_to", locked, 1);
      repeat (150) tick();
      chk("lock_after_to", locked, 0);
      chk("bypass_after_to", cfg_bypass, 1);
      chk("status_after_to", status, 4'b0001);

      // bouncing switches never reach pending, a stable value commits while unlocked
      upd_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         sw = sw ^ 8'h0F;
         repeat (8) tick();
      end
      repeat (40) tick();
      chk("mode_bounce", cfg_mode, 8'h05);
      chk("upd_bounce", upd_cnt, 0);
      sw = 8'h3C;
      repeat (40) tick();
      chk("mode_unlocked", cfg_mode, 8'h3C);
      chk("upd_unlocked", upd_cnt, 1);

      // reset mid-frame, then full relock
      vs_edge(); vs_tail();
      rx_dv = 1'b1;
      repeat (20) tick();
      rst = 1'b1; rx_dv = 1'b0;
      tick();
      chk_reset("midrst");
      rst = 1'b0;
      vs_edge(); vs_tail();
      frame(64, 16, 0, 0);
      vs_edge();
      chk("relock_vs2", locked, 0);
      vs_tail();
      frame(64, 16, 0, 0);
      vs_edge();
      chk("relock_vs3", locked, 1);
      chk("relock_h", h_active, 64);
      chk("relock_v", v_active, 16);
      chk("relock_bypass", cfg_bypass, 0);
      chk("relock_mode", cfg_mode, 8'h3C);
      vs_tail();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
